// File: rtl/sensor_pkg.sv
// Shared types and sizes for the sensor capture path.
// Imported by the buffer and the capture controller.
package sensor_pkg;

    localparam int SENSOR_DEPTH = 64;
    localparam int SENSOR_DW    = 32;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FULL
    } sensor_state_e;

endpackage

// File: rtl/sensor_buf.sv
// Sample buffer: one write port, one registered read port.
// Storage is deliberately not reset; only the read register is.
module sensor_buf
    import sensor_pkg::*;
#(
    parameter int DEPTH = SENSOR_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [SENSOR_DW-1:0]     i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [SENSOR_DW-1:0]     o_rdata
);

    logic [SENSOR_DW-1:0] r_mem [DEPTH];
    logic [SENSOR_DW-1:0] r_rdata;

    // Write port; contents survive reset and clear.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; a same-cycle write is seen next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sensor_ctrl_rx.sv
// Sensor capture controller: FSM, write pointer, sensor
// request and buffer-full interrupt around sensor_buf.
module sensor_ctrl_rx
    import sensor_pkg::*;
#(
    parameter int DEPTH = SENSOR_DEPTH
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst_n,
    input  logic                     sctrl_en,
    input  logic                     sctrl_clear,
    input  logic [$clog2(DEPTH)-1:0] sctrl_addr,
    output logic [SENSOR_DW-1:0]     sctrl_out,
    output logic                     sctrl_interrupt,
    output logic                     sensor_en,
    input  logic                     sensor_ready,
    input  logic [SENSOR_DW-1:0]     sensor_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    sensor_state_e r_state;
    sensor_state_e w_state_nxt;
    logic [AW:0]   r_wptr;
    logic [AW:0]   w_wptr_nxt;
    logic          r_sensor_en;
    logic          r_irq;
    logic          w_we;

    // Next state, write strobe and pointer update.
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_we        = (r_state == CAPTURE) && sensor_ready
                      && !sctrl_clear;
        if (w_we) begin
            w_wptr_nxt = r_wptr + ONE;
        end
        if (sctrl_clear) begin
            w_state_nxt = IDLE;
            w_wptr_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sctrl_en) begin
                        w_state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_we && (r_wptr == LAST)) begin
                        w_state_nxt = FULL;
                    end else if (!sctrl_en) begin
                        w_state_nxt = IDLE;
                    end
                end
                FULL: begin
                    w_state_nxt = FULL;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, pointer and registered outputs; outputs track the
    // state being entered so they change on the same edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_sensor_en <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_sensor_en <= (w_state_nxt == CAPTURE);
            r_irq       <= (w_state_nxt == FULL);
        end
    end

    assign sensor_en       = r_sensor_en;
    assign sctrl_interrupt = r_irq;

    sensor_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .i_clk   (cpu_clk),
        .i_rst_n (cpu_rst_n),
        .i_we    (w_we),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (sensor_out),
        .i_raddr (sctrl_addr),
        .o_rdata (sctrl_out)
    );

endmodule

// File: tb/tb_sensor_ctrl_rx.sv
// Bench for sensor_ctrl_rx against a sample-list model.
// Scenario tasks run in sequence from one initial block.
module tb_sensor_ctrl_rx;

    logic        cpu_clk   = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        en        = 1'b0;
    logic        clr       = 1'b0;
    logic        rdy       = 1'b0;
    logic [5:0]  addr      = '0;
    logic [31:0] dat       = '0;
    logic [31:0] rd_out;
    logic        irq;
    logic        sen;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [64];
    bit          m_vld [64];
    int          m_cnt;
    bit          m_cap;
    bit          m_full;
    logic [31:0] m_out;
    bit          m_out_vld;

    sensor_ctrl_rx #(.DEPTH(64)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst_n       (cpu_rst_n),
        .sctrl_en        (en),
        .sctrl_clear     (clr),
        .sctrl_addr      (addr),
        .sctrl_out       (rd_out),
        .sctrl_interrupt (irq),
        .sensor_en       (sen),
        .sensor_ready    (rdy),
        .sensor_out      (dat)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic model_reset();
        m_cnt     = 0;
        m_cap     = 0;
        m_full    = 0;
        m_out     = '0;
        m_out_vld = 1;
    endtask

    // Acquisition model: samples append to a list of at most 64.
    task automatic model_edge();
        logic [31:0] rd;
        bit          rv;
        rd = m_mem[addr];
        rv = m_vld[addr];
        if (clr) begin
            m_cnt  = 0;
            m_cap  = 0;
            m_full = 0;
        end else if (m_cap) begin
            if (rdy) begin
                m_mem[m_cnt] = dat;
                m_vld[m_cnt] = 1;
                m_cnt++;
            end
            if (m_cnt == 64) begin
                m_full = 1;
                m_cap  = 0;
            end else if (!en) begin
                m_cap = 0;
            end
        end else if (!m_full && en) begin
            m_cap = 1;
        end
        m_out     = rd;
        m_out_vld = rv;
    endtask

    task automatic cycle();
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic do_read(input int a);
        addr = 6'(a);
        cycle();
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b0;
        #2;
        n_tests++;
        if (sen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sen: got %b want 0", sen);
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq: got %b want 0", irq);
        end
        n_tests++;
        if (rd_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_out: got %h want 0", rd_out);
        end
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        model_reset();
        cycle();
        n_tests++;
        if (sen !== m_cap) begin
            n_fail++;
            $display("FAIL rst_idle_sen: got %b want %b", sen, m_cap);
        end
    endtask

    task automatic test_fill();
        en = 1'b1;
        cycle();
        n_tests++;
        if (sen !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_start_sen: got %b want 1", sen);
        end
        for (int i = 0; i < 64; i++) begin
            rdy = 1'b0;
            dat = 'x;
            repeat (1023) cycle();
            rdy = 1'b1;
            dat = 32'h1000 + 32'(i);
            cycle();
            rdy = 1'b0;
            dat = 'x;
            n_tests++;
            if (sen !== m_cap) begin
                n_fail++;
                $display("FAIL fill_sen[%0d]: got %b want %b",
                         i, sen, m_cap);
            end
            n_tests++;
            if (irq !== m_full) begin
                n_fail++;
                $display("FAIL fill_irq[%0d]: got %b want %b",
                         i, irq, m_full);
            end
        end
        dat = '0;
        for (int a = 0; a < 64; a++) begin
            do_read(a);
            n_tests++;
            if (rd_out !== (32'h1000 + 32'(a))) begin
                n_fail++;
                $display("FAIL fill_rd[%0d]: got %h want %h",
                         a, rd_out, 32'h1000 + 32'(a));
            end
        end
    endtask

    task automatic test_clear_collision();
        en  = 1'b0;
        clr = 1'b1;
        rdy = 1'b1;
        dat = 32'hDEAD;
        cycle();
        clr = 1'b0;
        rdy = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_irq: got %b want 0", irq);
        end
        n_tests++;
        if (sen !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_sen: got %b want 0", sen);
        end
        rdy = 1'b1;
        dat = 32'hBEEF;
        cycle();
        rdy = 1'b0;
        do_read(0);
        n_tests++;
        if (rd_out !== 32'h1000) begin
            n_fail++;
            $display("FAIL clr_buf0: got %h want %h", rd_out, 32'h1000);
        end
    endtask

    task automatic test_pause();
        logic [31:0] v;
        en = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            rdy = 1'b1;
            dat = $urandom;
            cycle();
            rdy = 1'b0;
        end
        en = 1'b0;
        cycle();
        n_tests++;
        if (sen !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_sen_off: got %b want 0", sen);
        end
        for (int i = 0; i < 5; i++) begin
            rdy = 1'b1;
            dat = $urandom;
            cycle();
            rdy = 1'b0;
            cycle();
        end
        en = 1'b1;
        cycle();
        n_tests++;
        if (sen !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_sen_on: got %b want 1", sen);
        end
        v   = $urandom;
        rdy = 1'b1;
        dat = v;
        cycle();
        rdy = 1'b0;
        en  = 1'b0;
        do_read(10);
        n_tests++;
        if (rd_out !== v) begin
            n_fail++;
            $display("FAIL pause_buf10: got %h want %h", rd_out, v);
        end
        do_read(11);
        n_tests++;
        if (rd_out !== m_out) begin
            n_fail++;
            $display("FAIL pause_buf11: got %h want %h", rd_out, m_out);
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b0;
        do_clear();
        en = 1'b1;
        cycle();
        rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dat = $urandom;
            cycle();
            if (i == 62) begin
                n_tests++;
                if (irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_irq_early: got %b want 0", irq);
                end
            end
        end
        rdy = 1'b0;
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_irq: got %b want 1", irq);
        end
        n_tests++;
        if (sen !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sen: got %b want 0", sen);
        end
        for (int a = 0; a < 64; a++) begin
            do_read(a);
            n_tests++;
            if (rd_out !== m_out) begin
                n_fail++;
                $display("FAIL b2b_rd[%0d]: got %h want %h",
                         a, rd_out, m_out);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        en = 1'b0;
        do_clear();
        en = 1'b1;
        cycle();
        rdy = 1'b1;
        repeat (30) begin
            dat = $urandom;
            cycle();
        end
        rdy = 1'b0;
        #4;
        cpu_rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (sen !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_sen: got %b want 0", sen);
        end
        n_tests++;
        if (rd_out !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_out: got %h want 0", rd_out);
        end
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        cycle();
        n_tests++;
        if (sen !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_resume_sen: got %b want 1", sen);
        end
        v   = $urandom;
        rdy = 1'b1;
        dat = v;
        cycle();
        rdy = 1'b0;
        en  = 1'b0;
        do_read(0);
        n_tests++;
        if (rd_out !== v) begin
            n_fail++;
            $display("FAIL arst_buf0: got %h want %h", rd_out, v);
        end
        do_read(1);
        n_tests++;
        if (rd_out !== m_out) begin
            n_fail++;
            $display("FAIL arst_buf1: got %h want %h", rd_out, m_out);
        end
    endtask

    task automatic test_x_guard();
        en = 1'b0;
        do_clear();
        en = 1'b1;
        cycle();
        rdy = 1'b1;
        repeat (5) begin
            dat = $urandom;
            cycle();
        end
        rdy = 1'b0;
        dat = 'x;
        repeat (100) cycle();
        en  = 1'b0;
        dat = '0;
        cycle();
        for (int a = 0; a < 64; a++) begin
            do_read(a);
            n_tests++;
            if ($isunknown(rd_out) || rd_out !== m_out) begin
                n_fail++;
                $display("FAIL xg_rd[%0d]: got %h want %h",
                         a, rd_out, m_out);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_vld[i] = 0;
            m_mem[i] = '0;
        end
        model_reset();
        test_reset();
        test_fill();
        test_clear_collision();
        test_pause();
        test_back_to_back();
        test_async_reset();
        test_x_guard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
